rob_multi_cdb: RTL and testbench
================================

# rob_multi_cdb

Parametrised reorder buffer for the out-of-order core. It sits between the Decoder (allocation and operand tag lookup), the N common data buses (ALU, branch unit, LS buffer) and the Regfile / LS buffer (in-order commit). It adds four things to the single-CDB ROB:
- configurable depth;
- N CDB write ports with lookup bypass;
- store and branch commit classes;
- a full flush on a mispredicted branch.

## Interface
Parameters:
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.
- `DATA_W`, 32: width of the data and target-PC fields.
- `REG_W`, 5: width of the architectural register name.
- `N_CDB`, 3: number of CDB write ports. Port 0 = ALU, 1 = branch, 2 = LSBuf.
- `TAG_W`, derived = $clog2(DEPTH)+1:
  - valid tag = {1'b0, index};
  - `TAG_FREE` = {1'b1, zeros} (operand has no producer).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ins_valid`  in  1  Decoder requests allocation.
- `ins_ready`  out  1  An entry is free (count < DEPTH).
- `ins_op`  in  2  Entry class: NORMAL=0, BRANCH=1, STORE=2.
- `ins_reg`  in  REG_W  Destination register; ignored unless NORMAL.
- `tail_tag`  out  TAG_W  Tag that the next allocation receives.
- `chk_tag[3]`  in  3×TAG_W  Operand lookup tags (rs1, rs2, rd).
- `chk_ready[3]`  out  3  Operand value is available.
- `chk_data[3]`  out  3×DATA_W  Operand value.
- `cdb_valid`  in  N_CDB  Per-port broadcast valid.
- `cdb_tag`  in  N_CDB×TAG_W  Per-port producer tag.
- `cdb_data`  in  N_CDB×DATA_W  Per-port result, or target PC on the branch port.
- `cdb_mispred`  in  N_CDB  Mispredict flag; only meaningful on BRANCH entries.
- `cm_reg_en`  out  1  Commit a NORMAL entry to the Regfile.
- `cm_reg_name`  out  REG_W  Register being committed.
- `cm_reg_data`  out  DATA_W  Value being committed.
- `cm_tag`  out  TAG_W  Tag of the committing entry (Regfile clears the matching rename).
- `cm_store`  out  1  Head is a STORE; LS buffer may perform it.
- `flush`  out  1  Mispredicted branch at head.
- `flush_pc`  out  DATA_W  Redirect target PC.

## Operation
- Entry fields:
  - `valid`, `ready`, `mispred`;
  - `op[1:0]`, `reg[REG_W-1:0]`, `data[DATA_W-1:0]`.
- Head/tail pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- **Allocate.** When `ins_valid && ins_ready` and there is no flush:
  - entry[tail] ← {valid=1, ready=0, mispred=0, op, reg};
  - tail++ and count++.
- **CDB write.** For each port p with `cdb_valid[p]`, tag MSB = 0, and the target entry valid:
  - set data ← `cdb_data[p]`, ready ← 1, mispred ← `cdb_mispred[p]`.
  - Writes to invalid entries or to `TAG_FREE` are ignored.
  - Two ports writing the same tag in one cycle is illegal; the lower port index wins.
- **Lookup** is combinational, per check port:
  - tag == `TAG_FREE` → ready=1, data=0;
  - else, any valid CDB port with a matching tag → ready=1, data from the lowest matching port;
  - else → entry ready and data;
  - invalid entry → ready=0.
- **Commit** is combinational from the head when `count != 0` and head.ready. Exactly one entry retires per cycle, on the rising edge:
  - NORMAL: `cm_reg_en`=1 with name/data; `cm_tag` = {0, head}.
  - STORE: `cm_store`=1.
  - BRANCH with mispred=0: retire silently.
  - BRANCH with mispred=1: `flush`=1, `flush_pc`=head.data.
- **Flush.** On the edge where `flush`=1:
  - every entry's valid is cleared;
  - head = tail = 0 and count = 0;
  - a same-cycle allocation is dropped;
  - same-cycle CDB writes are discarded.
- Simultaneous allocate and retire: count is unchanged; both pointers advance.

## Timing
- Reset (rst=0, asynchronous): all entries invalid; head=tail=count=0.
  - Outputs during reset: `ins_ready`=1, `tail_tag`=0, `cm_reg_en`=`cm_store`=`flush`=0, data outputs 0.
- Allocate → earliest CDB write is the next cycle.
- CDB write at edge k → the entry is ready from k. If it is the head, it commits in cycle k and retires at edge k+1.
- Lookup bypass is zero-latency within the broadcast cycle.
- `ins_ready` is computed from the pre-edge count only: a full ROB refuses allocation even while retiring.
- Wrap-around: tail passing DEPTH-1 goes to 0; full is count==DEPTH with head==tail.
- Reset asserted mid-operation discards all state immediately; no commit strobes are emitted.

## Structure
- Shared package `rob_pkg`:
  - op class constants NORMAL/BRANCH/STORE;
  - the entry struct;
  - the `TAG_FREE` function of TAG_W.
  - Decoder and LSBuf import the same package.
- One sub-module, `rob_lookup`: a single combinational check port with CDB bypass, instantiated three times.

## Test plan
- Reset, then allocate 16 NORMAL entries → `ins_ready`=0 after the 16th; a 17th `ins_valid` is ignored and `tail_tag` stays 0.
- Allocate tags 0 and 1; CDB0 writes tag 1 = 0xAA, then CDB1 writes tag 0 = 0x55 → commits reg of tag 0 with 0x55, then tag 1 with 0xAA, on consecutive cycles.
- CDB2 broadcasts tag 3 = 0x1234 while `chk_tag[1]`=3 → `chk_ready[1]`=1 and `chk_data[1]`=0x1234 in the same cycle; `TAG_FREE` → ready=1, data=0.
- Fill and drain 40 entries at full rate with allocate and commit every cycle → pointers wrap, count stays constant, and commit order matches allocation order.
- BRANCH at tag 2 gets mispred=1 with PC 0x400, and younger entries 3–5 are ready → `flush`=1 with `flush_pc`=0x400; entries 3–5 are never committed; afterwards `ins_ready`=1 and `tail_tag`=0.
- Assert `rst` low while 5 entries are valid → state clears immediately, no `cm_reg_en` is emitted, and the first post-reset allocation gets tag 0.

Source files
------------

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// rob_pkg : shared types for the reorder buffer, Decoder and LS buffer
// Revision 1.0
// ============================================================================
package rob_pkg;

    typedef enum logic [1:0] {
        OP_NORMAL = 2'd0,
        OP_BRANCH = 2'd1,
        OP_STORE  = 2'd2
    } rob_op_e;

    // Per-entry control bits; register name and data live in separate arrays
    // because their widths are module parameters.
    typedef struct packed {
        logic    valid;
        logic    ready;
        logic    mispred;
        rob_op_e op;
    } rob_ctl_t;

    localparam int MAX_TAG_W = 32;

    // TAG_FREE is the MSB-only pattern of a TAG_W-bit tag.
    function automatic logic [MAX_TAG_W-1:0] tag_free(input int tag_w);
        logic [MAX_TAG_W-1:0] t;
        t = '0;
        t[tag_w-1] = 1'b1;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_lookup.sv
`default_nettype none
// ============================================================================
// rob_lookup : one combinational operand check port with same-cycle CDB bypass
// Revision 1.0
// ============================================================================
module rob_lookup
    import rob_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 32,
    parameter  int N_CDB  = 3,
    localparam int TAG_W  = $clog2(DEPTH) + 1
) (
    input  logic [TAG_W-1:0]              chk_tag_i,
    input  logic [N_CDB-1:0]              cdb_valid_i,
    input  logic [N_CDB-1:0][TAG_W-1:0]   cdb_tag_i,
    input  logic [N_CDB-1:0][DATA_W-1:0]  cdb_data_i,
    input  logic [DEPTH-1:0]              ent_valid_i,
    input  logic [DEPTH-1:0]              ent_ready_i,
    input  logic [DATA_W-1:0]             ent_data_i [DEPTH],
    output logic                          ready_o,
    output logic [DATA_W-1:0]             data_o
);

    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(tag_free(TAG_W));

    logic [TAG_W-2:0]  w_idx;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    assign w_idx = chk_tag_i[TAG_W-2:0];

    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        // Scan high to low so the lowest matching port is the one kept.
        for (int p = N_CDB - 1; p >= 0; p--) begin
            if (cdb_valid_i[p] && (cdb_tag_i[p] == chk_tag_i)) begin
                w_hit      = 1'b1;
                w_hit_data = cdb_data_i[p];
            end
        end
    end

    always_comb begin
        ready_o = 1'b0;
        data_o  = '0;
        if (chk_tag_i == TAG_FREE) begin
            ready_o = 1'b1;
        end else if (w_hit) begin
            ready_o = 1'b1;
            data_o  = w_hit_data;
        end else if (!chk_tag_i[TAG_W-1] && ent_valid_i[w_idx]) begin
            ready_o = ent_ready_i[w_idx];
            data_o  = ent_data_i[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_multi_cdb.sv
`default_nettype none
// ============================================================================
// rob_multi_cdb : parametrised reorder buffer with N CDB ports, store/branch
//                 commit classes and full flush on a mispredicted branch
// Revision 1.0
// ============================================================================
module rob_multi_cdb
    import rob_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 32,
    parameter  int REG_W  = 5,
    parameter  int N_CDB  = 3,
    localparam int TAG_W  = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ins_valid,
    output logic                          ins_ready,
    input  logic [1:0]                    ins_op,
    input  logic [REG_W-1:0]              ins_reg,
    output logic [TAG_W-1:0]              tail_tag,
    input  logic [TAG_W-1:0]              chk_tag   [3],
    output logic [2:0]                    chk_ready,
    output logic [DATA_W-1:0]             chk_data  [3],
    input  logic [N_CDB-1:0]              cdb_valid,
    input  logic [N_CDB-1:0][TAG_W-1:0]   cdb_tag,
    input  logic [N_CDB-1:0][DATA_W-1:0]  cdb_data,
    input  logic [N_CDB-1:0]              cdb_mispred,
    output logic                          cm_reg_en,
    output logic [REG_W-1:0]              cm_reg_name,
    output logic [DATA_W-1:0]             cm_reg_data,
    output logic [TAG_W-1:0]              cm_tag,
    output logic                          cm_store,
    output logic                          flush,
    output logic [DATA_W-1:0]             flush_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rob_ctl_t          ctl_q  [DEPTH];
    rob_ctl_t          ctl_d  [DEPTH];
    logic [REG_W-1:0]  reg_q  [DEPTH];
    logic [REG_W-1:0]  reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    rob_ctl_t          w_head;
    logic              w_commit;
    logic              w_alloc;
    logic [DEPTH-1:0]  w_ent_valid;
    logic [DEPTH-1:0]  w_ent_ready;

    assign w_head    = ctl_q[head_q];
    assign w_commit  = (count_q != '0) && w_head.valid && w_head.ready;
    assign ins_ready = (count_q < CNT_W'(DEPTH));
    assign w_alloc   = ins_valid && ins_ready;
    assign tail_tag  = {1'b0, tail_q};

    assign cm_reg_en   = w_commit && (w_head.op == OP_NORMAL);
    assign cm_store    = w_commit && (w_head.op == OP_STORE);
    assign flush       = w_commit && (w_head.op == OP_BRANCH) && w_head.mispred;
    assign cm_reg_name = cm_reg_en ? reg_q[head_q]  : '0;
    assign cm_reg_data = cm_reg_en ? data_q[head_q] : '0;
    assign flush_pc    = flush     ? data_q[head_q] : '0;
    assign cm_tag      = {1'b0, head_q};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_valid[i] = ctl_q[i].valid;
            w_ent_ready[i] = ctl_q[i].ready;
        end
    end

    always_comb begin
        ctl_d   = ctl_q;
        reg_d   = reg_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Same-cycle allocation and CDB writes are dropped with everything else.
            for (int i = 0; i < DEPTH; i++) begin
                ctl_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int p = N_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && !cdb_tag[p][TAG_W-1] &&
                    ctl_q[cdb_tag[p][PTR_W-1:0]].valid) begin
                    ctl_d[cdb_tag[p][PTR_W-1:0]].ready   = 1'b1;
                    ctl_d[cdb_tag[p][PTR_W-1:0]].mispred = cdb_mispred[p];
                    data_d[cdb_tag[p][PTR_W-1:0]]        = cdb_data[p];
                end
            end
            if (w_commit) begin
                ctl_d[head_q].valid = 1'b0;
                head_d              = head_q + 1'b1;
            end
            if (w_alloc) begin
                ctl_d[tail_q].valid   = 1'b1;
                ctl_d[tail_q].ready   = 1'b0;
                ctl_d[tail_q].mispred = 1'b0;
                ctl_d[tail_q].op      = rob_op_e'(ins_op);
                reg_d[tail_q]         = ins_reg;
                tail_d                = tail_q + 1'b1;
            end
            count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_commit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctl_q[i]  <= '0;
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ctl_q   <= ctl_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_chk
        rob_lookup #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .N_CDB  (N_CDB)
        ) u_lookup (
            .chk_tag_i   (chk_tag[k]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .ent_valid_i (w_ent_valid),
            .ent_ready_i (w_ent_ready),
            .ent_data_i  (data_q),
            .ready_o     (chk_ready[k]),
            .data_o      (chk_data[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_cdb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_rob_multi_cdb : self-checking bench for rob_multi_cdb
// Revision 1.0
// ============================================================================
module tb_rob_multi_cdb;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int N_CDB  = 3;
    localparam int TAG_W  = 5;
    localparam logic [TAG_W-1:0] TFREE = 5'h10;
    localparam logic [1:0] NRM = 2'd0, BRN = 2'd1, STR = 2'd2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         ins_valid;
    logic                         ins_ready;
    logic [1:0]                   ins_op;
    logic [REG_W-1:0]             ins_reg;
    logic [TAG_W-1:0]             tail_tag;
    logic [TAG_W-1:0]             chk_tag  [3];
    logic [2:0]                   chk_ready;
    logic [DATA_W-1:0]            chk_data [3];
    logic [N_CDB-1:0]             cdb_valid;
    logic [N_CDB-1:0][TAG_W-1:0]  cdb_tag;
    logic [N_CDB-1:0][DATA_W-1:0] cdb_data;
    logic [N_CDB-1:0]             cdb_mispred;
    logic                         cm_reg_en;
    logic [REG_W-1:0]             cm_reg_name;
    logic [DATA_W-1:0]            cm_reg_data;
    logic [TAG_W-1:0]             cm_tag;
    logic                         cm_store;
    logic                         flush;
    logic [DATA_W-1:0]            flush_pc;

    rob_multi_cdb #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .N_CDB(N_CDB)
    ) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_reg(ins_reg),
        .tail_tag(tail_tag),
        .chk_tag(chk_tag), .chk_ready(chk_ready), .chk_data(chk_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_mispred(cdb_mispred),
        .cm_reg_en(cm_reg_en), .cm_reg_name(cm_reg_name), .cm_reg_data(cm_reg_data),
        .cm_tag(cm_tag), .cm_store(cm_store), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_commits = 0;

    typedef struct {
        logic [REG_W-1:0]  rname;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int               port;
        logic [TAG_W-1:0] tag;
        logic [2:0]       cv;
        logic [TAG_W-1:0] t0, t1, t2;
        logic [DATA_W-1:0] d0, d1, d2;
        logic             exp_rdy;
        logic [DATA_W-1:0] exp_data;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int r, input logic [DATA_W-1:0] d, input int t);
        exp_t e;
        e.rname = REG_W'(r);
        e.data  = d;
        e.tag   = TAG_W'(t);
        sb.push_back(e);
    endtask

    function automatic logic [DATA_W-1:0] dval(input int s);
        return 32'hC000_0000 + DATA_W'(s * 17);
    endfunction

    // Commit scoreboard: every register commit must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && cm_reg_en === 1'b1) begin
            n_commits++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_commit: got tag 0x%0h reg 0x%0h, expected no commit", cm_tag, cm_reg_name);
            end else begin
                mon_e = sb.pop_front();
                check("commit_reg",  cm_reg_name, mon_e.rname);
                check("commit_data", cm_reg_data, mon_e.data);
                check("commit_tag",  cm_tag,      mon_e.tag);
            end
        end
    end

    task automatic idle_inputs();
        ins_valid   = 1'b0;
        ins_op      = NRM;
        ins_reg     = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_data    = '0;
        cdb_mispred = '0;
        for (int k = 0; k < 3; k++) chk_tag[k] = TFREE;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] op, input int r);
        ins_valid = 1'b1;
        ins_op    = op;
        ins_reg   = REG_W'(r);
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic cdb(input int p, input int t, input logic [DATA_W-1:0] d, input logic mp);
        cdb_valid[p]   = 1'b1;
        cdb_tag[p]     = TAG_W'(t);
        cdb_data[p]    = d;
        cdb_mispred[p] = mp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1'b0;
        idle_inputs();
        #2;
        check("rst_ins_ready", ins_ready, 1);
        check("rst_tail_tag",  tail_tag,  0);
        check("rst_cm_reg_en", cm_reg_en, 0);
        check("rst_cm_store",  cm_store,  0);
        check("rst_flush",     flush,     0);
        check("rst_flush_pc",  flush_pc,  0);
        check("rst_cm_data",   cm_reg_data, 0);
        repeat (2) tick();
        rst = 1'b1;

        // Fill to capacity; the 17th request must be refused.
        for (int i = 0; i < 16; i++) begin
            ins_valid = 1'b1; ins_op = NRM; ins_reg = REG_W'(i);
            samp();
            check("fill_tail_tag",  tail_tag,  64'(i));
            check("fill_ins_ready", ins_ready, 1);
            tick();
        end
        samp();
        check("full_ins_ready", ins_ready, 0);
        check("full_tail_tag",  tail_tag,  0);
        tick();
        ins_valid = 1'b0;
        samp();
        check("full17_tail_tag",  tail_tag,  0);
        check("full17_ins_ready", ins_ready, 0);
        do_reset();

        // Out-of-order completion, in-order commit.
        alloc(NRM, 5); push_exp(5, 32'h55, 0);
        alloc(NRM, 6); push_exp(6, 32'hAA, 1);
        cdb(0, 1, 32'hAA, 1'b0);
        tick(); idle_inputs();
        cdb(1, 0, 32'h55, 1'b0);
        samp();
        check("ooo_no_early_commit", cm_reg_en, 0);
        tick(); idle_inputs();
        samp();
        check("ooo_commit0_en",  cm_reg_en, 1);
        check("ooo_commit0_tag", cm_tag,    0);
        tick();
        samp();
        check("ooo_commit1_en",  cm_reg_en, 1);
        check("ooo_commit1_tag", cm_tag,    1);
        tick();
        samp();
        check("ooo_idle_en",    cm_reg_en, 0);
        check("ooo_tail_tag",   tail_tag,  2);
        do_reset();

        // Lookup table: entries 0..3 allocated, only entry 2 ready (0x22).
        vt[0]  = '{0, TFREE,  3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b1, 32'h0};
        vt[1]  = '{1, 5'd2,   3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b1, 32'h22};
        vt[2]  = '{2, 5'd1,   3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b0, 32'h0};
        vt[3]  = '{0, 5'd9,   3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b0, 32'h0};
        vt[4]  = '{1, 5'd9,   3'b010, 5'd0, 5'd9, 5'd0, 32'h0,  32'h99, 32'h0,    1'b1, 32'h99};
        vt[5]  = '{2, 5'd9,   3'b101, 5'd9, 5'd0, 5'd9, 32'h5,  32'h0,  32'h6,    1'b1, 32'h5};
        vt[6]  = '{0, 5'd9,   3'b101, 5'd8, 5'd0, 5'd9, 32'h7,  32'h0,  32'h6,    1'b1, 32'h6};
        vt[7]  = '{1, 5'h11,  3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b0, 32'h0};
        vt[8]  = '{1, 5'd3,   3'b100, 5'd0, 5'd0, 5'd3, 32'h0,  32'h0,  32'h1234, 1'b1, 32'h1234};
        vt[9]  = '{2, 5'd3,   3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b1, 32'h1234};
        vt[10] = '{0, 5'd1,   3'b000, 5'd1, 5'd0, 5'd0, 32'hFF, 32'h0,  32'h0,    1'b0, 32'h0};
        vt[11] = '{2, 5'd0,   3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,    1'b0, 32'h0};
        for (int r = 0; r < 4; r++) alloc(NRM, r);
        cdb(0, 2, 32'h22, 1'b0);
        tick(); idle_inputs();
        for (int i = 0; i < 12; i++) begin
            chk_tag[vt[i].port] = vt[i].tag;
            cdb_valid  = vt[i].cv;
            cdb_tag[0] = vt[i].t0;  cdb_tag[1] = vt[i].t1;  cdb_tag[2] = vt[i].t2;
            cdb_data[0] = vt[i].d0; cdb_data[1] = vt[i].d1; cdb_data[2] = vt[i].d2;
            samp();
            for (int k = 0; k < 3; k++) begin
                if (k == vt[i].port) begin
                    check($sformatf("lut%0d_rdy", i), chk_ready[k], vt[i].exp_rdy);
                    if (vt[i].exp_rdy) check($sformatf("lut%0d_data", i), chk_data[k], vt[i].exp_data);
                end else begin
                    check($sformatf("lut%0d_free%0d_rdy", i, k), chk_ready[k], 1);
                    check($sformatf("lut%0d_free%0d_data", i, k), chk_data[k], 0);
                end
            end
            check($sformatf("lut%0d_no_commit", i), cm_reg_en, 0);
            tick(); idle_inputs();
        end
        do_reset();

        // Full-rate streaming: one allocate and one commit every cycle, 40 entries.
        for (int s = 0; s < 4; s++) begin
            push_exp(s % 32, dval(s), s % 16);
            alloc(NRM, s % 32);
        end
        c0 = n_commits;
        for (int i = 0; i < 40; i++) begin
            ins_valid = 1'b1; ins_op = NRM; ins_reg = REG_W'((4 + i) % 32);
            if (4 + i < 40) push_exp((4 + i) % 32, dval(4 + i), (4 + i) % 16);
            cdb(0, i % 16, dval(i), 1'b0);
            samp();
            check("stream_tail_tag",  tail_tag,  64'((4 + i) % 16));
            check("stream_ins_ready", ins_ready, 1);
            if (i >= 1) begin
                check("stream_commit_en", cm_reg_en, 1);
                check("stream_occupancy", (tail_tag - cm_tag) & 5'hF, 5);
            end
            tick(); idle_inputs();
        end
        samp();
        check("stream_last_commit", cm_reg_en, 1);
        tick();
        samp();
        check("stream_drained_en", cm_reg_en, 0);
        check("stream_commit_count", n_commits - c0, 40);
        check("stream_sb_empty", sb.size(), 0);
        do_reset();

        // Store commit and silent correctly-predicted branch.
        alloc(STR, 7);
        alloc(BRN, 0);
        cdb(0, 0, 32'h1, 1'b0);
        cdb(1, 1, 32'h800, 1'b0);
        tick(); idle_inputs();
        samp();
        check("store_cm_store", cm_store,  1);
        check("store_cm_reg",   cm_reg_en, 0);
        check("store_cm_tag",   cm_tag,    0);
        tick();
        samp();
        check("br_ok_store", cm_store,  0);
        check("br_ok_flush", flush,     0);
        check("br_ok_reg",   cm_reg_en, 0);
        check("br_ok_tag",   cm_tag,    1);
        tick();
        samp();
        check("br_ok_retired_tag", cm_tag, 2);
        check("br_ok_idle_flush",  flush,  0);
        do_reset();

        // Mispredicted branch flush with ready younger entries.
        alloc(NRM, 1); push_exp(1, 32'h10, 0);
        alloc(NRM, 2); push_exp(2, 32'h20, 1);
        alloc(BRN, 0);
        alloc(NRM, 3);
        alloc(NRM, 4);
        alloc(NRM, 5);
        cdb(0, 3, 32'h33, 1'b0); cdb(1, 4, 32'h44, 1'b0); cdb(2, 5, 32'h55, 1'b0);
        tick(); idle_inputs();
        cdb(1, 2, 32'h400, 1'b1);
        tick(); idle_inputs();
        cdb(0, 0, 32'h10, 1'b0); cdb(2, 1, 32'h20, 1'b0);
        tick(); idle_inputs();
        samp();
        check("fl_c0_en",    cm_reg_en, 1);
        check("fl_c0_flush", flush,     0);
        tick();
        samp();
        check("fl_c1_en",  cm_reg_en, 1);
        check("fl_c1_tag", cm_tag,    1);
        tick();
        ins_valid = 1'b1; ins_op = NRM; ins_reg = 5'd9;
        cdb(0, 0, 32'hDEAD, 1'b0);
        samp();
        check("fl_flush",    flush,     1);
        check("fl_flush_pc", flush_pc,  32'h400);
        check("fl_reg_en",   cm_reg_en, 0);
        check("fl_tag",      cm_tag,    2);
        tick(); idle_inputs();
        chk_tag[0] = 5'd0; chk_tag[2] = 5'd3;
        samp();
        check("fl_after_flush",     flush,        0);
        check("fl_after_ins_ready", ins_ready,    1);
        check("fl_after_tail_tag",  tail_tag,     0);
        check("fl_dropped_alloc",   chk_ready[0], 0);
        check("fl_young_cleared",   chk_ready[2], 0);
        check("fl_after_reg_en",    cm_reg_en,    0);
        tick(); idle_inputs();
        repeat (2) begin
            samp();
            check("fl_quiet_reg_en", cm_reg_en, 0);
            tick();
        end
        do_reset();

        // Asynchronous reset with five live entries.
        for (int r = 0; r < 5; r++) alloc(NRM, 10 + r);
        cdb(0, 1, 32'h1, 1'b0); cdb(1, 2, 32'h2, 1'b0); cdb(2, 3, 32'h3, 1'b0);
        tick(); idle_inputs();
        samp();
        check("ar_pre_reg_en", cm_reg_en, 0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ins_ready", ins_ready, 1);
        check("ar_tail_tag",  tail_tag,  0);
        check("ar_reg_en",    cm_reg_en, 0);
        check("ar_cm_tag",    cm_tag,    0);
        repeat (2) tick();
        rst = 1'b1;
        ins_valid = 1'b1; ins_op = NRM; ins_reg = 5'd20;
        samp();
        check("ar_first_tag", tail_tag, 0);
        tick(); idle_inputs();
        push_exp(20, 32'h77, 0);
        cdb(0, 0, 32'h77, 1'b0);
        tick(); idle_inputs();
        samp();
        check("ar_commit_en",  cm_reg_en, 1);
        check("ar_commit_tag", cm_tag,    0);
        tick();
        samp();

        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
